// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port RAM with registered read data.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin; default is fixed priority (port 0 wins).
module mem_arbiter #(
    parameter int MEM_ADDR = 16,
    parameter int LEN_REG  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p0_req,
    input  logic                p0_we,
    input  logic [MEM_ADDR-1:0] p0_addr,
    input  logic [LEN_REG-1:0]  p0_wdata,
    output logic                p0_gnt,
    output logic                p0_rvalid,
    output logic [LEN_REG-1:0]  p0_rdata,
    input  logic                p1_req,
    input  logic                p1_we,
    input  logic [MEM_ADDR-1:0] p1_addr,
    input  logic [LEN_REG-1:0]  p1_wdata,
    output logic                p1_gnt,
    output logic                p1_rvalid,
    output logic [LEN_REG-1:0]  p1_rdata,
    output logic [MEM_ADDR-1:0] mem_A,
    output logic                mem_W,
    output logic [LEN_REG-1:0]  mem_D,
    input  logic [LEN_REG-1:0]  mem_Q
);

    // Handshake: a request is held with its addr/we/wdata until pN_gnt is seen
    // high in the same cycle; the access is issued to the RAM in that cycle.
    logic rd_valid_q, rd_valid_d;
    logic rd_owner_q, rd_owner_d;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_gnt_q, last_gnt_d;
`endif

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            if (p0_req && p1_req) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                // On conflict the port that did not win last time goes first.
                if (last_gnt_q) p0_gnt = 1'b1;
                else            p1_gnt = 1'b1;
`else
                p0_gnt = 1'b1;
`endif
            end else begin
                p0_gnt = p0_req;
                p1_gnt = p1_req;
            end
        end
    end

    always_comb begin
        mem_A = '0;
        mem_W = 1'b0;
        mem_D = '0;
        if (p0_gnt) begin
            mem_A = p0_addr;
            mem_W = p0_we;
            mem_D = p0_wdata;
        end else if (p1_gnt) begin
            mem_A = p1_addr;
            mem_W = p1_we;
            mem_D = p1_wdata;
        end
    end

    always_comb begin
        rd_valid_d = (p0_gnt && !p0_we) || (p1_gnt && !p1_we);
        rd_owner_d = p1_gnt;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        last_gnt_d = last_gnt_q;
        if (p0_gnt || p1_gnt) last_gnt_d = p1_gnt;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_owner_q <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_gnt_q <= 1'b1;
`endif
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_owner_q <= rd_owner_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    // A reset arriving while a read return is in flight discards that return.
    assign p0_rvalid = rd_valid_q && !rd_owner_q && !rst;
    assign p1_rvalid = rd_valid_q &&  rd_owner_q && !rst;
    assign p0_rdata  = mem_Q;
    assign p1_rdata  = mem_Q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural registered-read RAM model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [15:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [15:0] mem_A;
    logic        mem_W;
    logic [31:0] mem_D, mem_Q;

    logic [31:0] ram [0:65535];

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter #(.MEM_ADDR(16), .LEN_REG(32)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_A(mem_A), .mem_W(mem_W), .mem_D(mem_D), .mem_Q(mem_Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_W) ram[mem_A] <= mem_D;
        mem_Q <= ram[mem_A];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one cycle's inputs at the falling edge, then settle before checks.
    task automatic drive(input logic r, input logic r0, input logic w0, input logic [15:0] a0,
                         input logic [31:0] d0, input logic r1, input logic w1,
                         input logic [15:0] a1, input logic [31:0] d1);
        @(negedge clk);
        rst = r;
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    endtask

    logic exp_own [4];
    logic prev_own;

    initial begin
        rst = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        exp_own[0] = 1'b0; exp_own[1] = 1'b1; exp_own[2] = 1'b0; exp_own[3] = 1'b1;
`else
        exp_own[0] = 1'b0; exp_own[1] = 1'b0; exp_own[2] = 1'b0; exp_own[3] = 1'b0;
`endif

        // Reset held with a pending write request: nothing may be granted.
        drive(1'b1, 1'b1, 1'b1, 16'h1234, 32'hCAFEF00D, 1'b1, 1'b1, 16'h4321, 32'h1);
        chk("rst_gnt0", p0_gnt, 0);
        chk("rst_gnt1", p1_gnt, 0);
        chk("rst_memW", mem_W, 0);
        chk("rst_memA", mem_A, 0);
        chk("rst_memD", mem_D, 0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
        chk("rst_rv0", p0_rvalid, 0);
        chk("rst_rv1", p1_rvalid, 0);

        // p0 write, then read back.
        drive(1'b0, 1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b0, 16'h0, 32'h0);
        chk("wr_gnt0", p0_gnt, 1);
        chk("wr_gnt1", p1_gnt, 0);
        chk("wr_memW", mem_W, 1);
        chk("wr_memA", mem_A, 16'h0010);
        chk("wr_memD", mem_D, 32'hDEADBEEF);
        chk("wr_rv0", p0_rvalid, 0);
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
        chk("rd_gnt0", p0_gnt, 1);
        chk("rd_memW", mem_W, 0);
        chk("rd_memA", mem_A, 16'h0010);
        chk("rd_rv0_early", p0_rvalid, 0);
        chk("wr_no_rvalid1", p1_rvalid, 0);
        idle();
        chk("rd_rv0", p0_rvalid, 1);
        chk("rd_rdata0", p0_rdata, 32'hDEADBEEF);
        chk("rd_rv1", p1_rvalid, 0);
        idle();
        chk("rd_rv0_once", p0_rvalid, 0);

        // p1 preloads a second address for the conflict phase.
        drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 16'h0020, 32'h0BADF00D);
        chk("p1wr_gnt1", p1_gnt, 1);
        chk("p1wr_memA", mem_A, 16'h0020);

        // Both ports hold reads for four cycles.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b0, 16'h0020, 32'h0);
            chk($sformatf("cf%0d_gnt0", k), p0_gnt, !exp_own[k]);
            chk($sformatf("cf%0d_gnt1", k), p1_gnt, exp_own[k]);
            chk($sformatf("cf%0d_memA", k), mem_A, exp_own[k] ? 16'h0020 : 16'h0010);
            if (k > 0) begin
                chk($sformatf("cf%0d_rv0", k), p0_rvalid, !prev_own);
                chk($sformatf("cf%0d_rv1", k), p1_rvalid, prev_own);
                chk($sformatf("cf%0d_rdata", k), prev_own ? p1_rdata : p0_rdata,
                    prev_own ? 32'h0BADF00D : 32'hDEADBEEF);
            end
            prev_own = exp_own[k];
        end
        idle();
        chk("cf_last_rv0", p0_rvalid, !prev_own);
        chk("cf_last_rv1", p1_rvalid, prev_own);
        chk("cf_last_rdata", prev_own ? p1_rdata : p0_rdata,
            prev_own ? 32'h0BADF00D : 32'hDEADBEEF);

        // Top-of-range address: write then immediate read-back on port 1.
        drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 16'hFFFF, 32'h12345678);
        chk("top_wr_gnt1", p1_gnt, 1);
        chk("top_wr_memA", mem_A, 16'hFFFF);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 16'hFFFF, 32'h0);
        chk("top_rd_gnt1", p1_gnt, 1);
        chk("top_rd_rv1_early", p1_rvalid, 0);
        idle();
        chk("top_rv1", p1_rvalid, 1);
        chk("top_rdata1", p1_rdata, 32'h12345678);
        chk("top_rv0", p0_rvalid, 0);

        // Reset right after a p1 read grant drops the return.
        drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 16'hFFFF, 32'h0);
        chk("drop_gnt1", p1_gnt, 1);
        drive(1'b1, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b0, 16'h0020, 32'h0);
        chk("drop_rv1", p1_rvalid, 0);
        chk("drop_gnt0", p0_gnt, 0);
        chk("drop_gnt1_rst", p1_gnt, 0);
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b0, 16'h0020, 32'h0);
        chk("post_rst_gnt0", p0_gnt, 1);
        chk("post_rst_gnt1", p1_gnt, 0);
        chk("post_rst_rv1", p1_rvalid, 0);
        idle();
        chk("post_rst_rv0", p0_rvalid, 1);
        chk("post_rst_rdata0", p0_rdata, 32'hDEADBEEF);

        // Three idle cycles.
        for (int k = 0; k < 3; k++) begin
            idle();
            chk($sformatf("idle%0d_gnt", k), {p0_gnt, p1_gnt}, 0);
            chk($sformatf("idle%0d_memW", k), mem_W, 0);
            chk($sformatf("idle%0d_memA", k), mem_A, 0);
            chk($sformatf("idle%0d_rv", k), {p0_rvalid, p1_rvalid}, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_ADDR, default 16: memory word-address width.
REQ-002 Parameter LEN_REG, default 32: data word width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 p0_req  in  1  port 0 access request; held with address and data until granted.
REQ-006 p0_we  in  1  port 0 write (1) / read (0).
REQ-007 p0_addr  in  MEM_ADDR  port 0 word address.
REQ-008 p0_wdata  in  LEN_REG  port 0 write data.
REQ-009 p0_gnt  out  1  port 0 request accepted this cycle (combinational).
REQ-010 p0_rvalid  out  1  port 0 read data valid on p0_rdata.
REQ-011 p0_rdata  out  LEN_REG  port 0 read data.
REQ-012 p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same widths and meanings as port 0, for port 1.
REQ-013 mem_A  out  MEM_ADDR  address to the single-port RAM.
REQ-014 mem_W  out  1  RAM write enable.
REQ-015 mem_D  out  LEN_REG  RAM write data.
REQ-016 mem_Q  in  LEN_REG  RAM registered read data; valid the cycle after a read is issued.

Function
REQ-017 At most one of p0_gnt/p1_gnt is high per cycle; pN_gnt is never high unless pN_req is high.
REQ-018 Granted port's addr/we/wdata drive mem_A/mem_W/mem_D combinationally in the grant cycle.
REQ-019 With no grant: mem_W=0, mem_A=0, mem_D=0.
REQ-020 Grant is issued every cycle at least one request is present; there are no idle bubbles and no back-to-back penalty.
REQ-021 Read latency is 1 cycle: a read granted in cycle N produces pN_rvalid=1 in cycle N+1 only, with pN_rdata=mem_Q.
REQ-022 Writes produce no rvalid; a write granted in cycle N followed by a read of the same address granted in N+1 returns the new data in N+2.
REQ-023 A one-bit registered return tag records the read owner; p0_rdata and p1_rdata both equal mem_Q, and only the owner's rvalid asserts.
REQ-024 The port-selection policy, including last_gnt handling, is defined in REQ-030/REQ-031.
REQ-025 Pipelined accesses are supported: a new grant in cycle N+1 may coincide with the rvalid for cycle N.

Reset
REQ-026 While rst=1: p0_gnt=p1_gnt=0, mem_W=0, mem_A=0, mem_D=0, and mem_W is never asserted.
REQ-027 At the clock edge with rst=1: p0_rvalid=p1_rvalid=0 and last_gnt=1 (port 0 favoured first).
REQ-028 rst asserted in the cycle after a read grant drops that return: no rvalid is produced, and the requester must reissue.
REQ-029 Grants resume in the first cycle with rst=0.

Configuration
REQ-030 With macro MEM_ARBITER_ROUND_ROBIN_EN defined: round-robin arbitration.
- On conflict, grant the port that is not last_gnt.
- last_gnt updates to the granted port on every grant.
- A lone requester is always granted.
REQ-031 Without MEM_ARBITER_ROUND_ROBIN_EN: fixed priority.
- Port 0 always wins a conflict.
- last_gnt is unused and port 1 may starve.

Verification
REQ-032 Reset, then p0 writes 0xDEADBEEF to 0x0010 -> p0_gnt=1 in the same cycle, mem_W=1, mem_A=0x0010, mem_D=0xDEADBEEF, no rvalid.
REQ-033 p0 reads 0x0010 after the write -> p0_rvalid=1 exactly one cycle after grant, p0_rdata=0xDEADBEEF, p1_rvalid=0.
REQ-034 p0 and p1 both hold read requests for 4 cycles.
- With RR: grants go p0,p1,p0,p1.
- Without RR: p0 is granted all 4 cycles.
- Each rvalid goes only to the owning port.
REQ-035 p1 writes 0x12345678 to 0xFFFF in cycle N, p1 reads 0xFFFF in N+1 -> p1_rvalid in N+2 with 0x12345678 (address wrap-top boundary).
REQ-036 rst pulsed in the cycle after a p1 read grant -> p1_rvalid stays 0.
- After reset, a conflict grants p0 first.
REQ-037 No requests for 3 cycles -> no gnt, mem_W=0, mem_A=0, no rvalid.
